led_pulse_stretch: RTL and testbench

Output-side counterpart to the board's button input conditioning: it turns short internal single-cycle events (e.g. FIFO push, pop, full hit) into LED flashes long enough to be seen. Each accepted event produces exactly one flash of fixed on-time, followed by a guaranteed off-gap. Events that arrive while a flash is in progress are queued in a saturating counter. Instances sit between the FIFO status logic and the board LED pins.

---
 rtl/fifo_ui_pkg.sv | 21 ++
 rtl/led_pulse_stretch_if.sv | 23 ++
 rtl/sat_counter.sv | 35 +++
 rtl/led_pulse_stretch.sv | 128 ++++++++++++
 tb/tb_led_pulse_stretch.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fifo_ui_pkg.sv
// Shared encodings and helpers for the FIFO board UI blocks.
// LED stretcher FSM states plus a constant-function clog2.
package fifo_ui_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pulse_stretch_if.sv
// Event/clear inputs and LED/status outputs of the pulse stretcher.
interface led_pulse_stretch_if #(
    parameter int PEND_W = 2
);

    logic              event_in;
    logic              clear;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_in, clear,
        input  led_out, busy, pending, overflow
    );

    modport slave (
        input  event_in, clear,
        output led_out, busy, pending, overflow
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter holding the queued-event count.
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = &cnt_q;
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            clr:                         cnt_d = '0;
            (inc && !dec && !sat):       cnt_d = cnt_q + 1'b1;
            (dec && !inc && cnt_q != 0): cnt_d = cnt_q - 1'b1;
            default:                     cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle events into visible LED flashes with an off-gap,
// queueing events that arrive mid-flash in a saturating counter.
module led_pulse_stretch
    import fifo_ui_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PEND_W     = 2
) (
    input logic          clk,
    input logic          n_reset,
    led_pulse_stretch_if.slave bus
);

    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = clog2(MAXC + 1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (ON_CYCLES < 1) begin : g_bad_on
        $error("led_pulse_stretch: ON_CYCLES must be >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [PEND_W-1:0] pend;
    logic              pend_sat;
    logic              pend_inc;
    logic              pend_dec;
    logic              end_gap;
    logic              last;
    logic              ev;

    assign ev   = bus.event_in;
    assign last = (timer_q == '0);

    sat_counter #(.W(PEND_W)) u_pend (
        .clk (clk),
        .rst (n_reset),
        .inc (pend_inc),
        .dec (pend_dec),
        .clr (bus.clear),
        .cnt (pend),
        .sat (pend_sat)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ovf_d    = ovf_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        end_gap  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            timer_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (1'b1)
                (state_q == ST_IDLE): begin
                    if (ev) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                    end
                end
                (state_q == ST_ON): begin
                    if (!last) begin
                        timer_d = timer_q - 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        end_gap = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        timer_d = GAP_LOAD;
                    end
                end
                (state_q == ST_GAP): begin
                    if (last) end_gap = 1'b1;
                    else      timer_d = timer_q - 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
            // A same-cycle event at end of gap replaces the dequeue.
            if (end_gap) begin
                if (pend != '0 || ev) begin
                    state_d  = ST_ON;
                    timer_d  = ON_LOAD;
                    pend_dec = (pend != '0) && !ev;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end else if (state_q != ST_IDLE && ev) begin
                if (pend_sat) ovf_d = 1'b1;
                else          pend_inc = 1'b1;
            end
        end
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Scoreboard bench for led_pulse_stretch with directed per-cycle vectors.
module tb_led_pulse_stretch;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } obs_t;

    logic clk = 1'b0;
    logic n_reset = 1'b1;
    always #5 clk = ~clk;

    led_pulse_stretch_if #(.PEND_W(2)) bus ();

    led_pulse_stretch #(
        .ON_CYCLES (4),
        .GAP_CYCLES(2),
        .PEND_W    (2)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string nm, input obs_t exp);
        obs_t act;
        act = {bus.led_out, bus.busy, bus.pending, bus.overflow};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got led=%0b busy=%0b pend=%0d ovf=%0b, want led=%0b busy=%0b pend=%0d ovf=%0b",
                     nm, $time, act.led, act.busy, act.pend, act.ovf,
                     exp.led, exp.busy, exp.pend, exp.ovf);
        end
    endtask

    // Monitor: one expected observation per edge that the driver armed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(tag_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic row(input string nm, input int rep, input logic ev,
                       input logic clr, input logic led, input logic busy,
                       input logic [1:0] pend, input logic ovf);
        obs_t e;
        e = {led, busy, pend, ovf};
        repeat (rep) begin
            @(negedge clk);
            bus.event_in = ev;
            bus.clear    = clr;
            exp_q.push_back(e);
            tag_q.push_back(nm);
        end
    endtask

    initial begin
        bus.event_in = 1'b0;
        bus.clear    = 1'b0;
        #3;
        check("reset_state", '0);
        @(negedge clk);
        n_reset = 1'b0;

        // single flash
        row("t1", 1, 1, 0, 1, 1, 0, 0);
        row("t1", 3, 0, 0, 1, 1, 0, 0);
        row("t1", 2, 0, 0, 0, 1, 0, 0);
        row("t1", 1, 0, 0, 0, 0, 0, 0);

        // three back-to-back events
        row("t2", 1, 1, 0, 1, 1, 0, 0);
        row("t2", 1, 1, 0, 1, 1, 1, 0);
        row("t2", 1, 1, 0, 1, 1, 2, 0);
        row("t2", 1, 0, 0, 1, 1, 2, 0);
        row("t2", 2, 0, 0, 0, 1, 2, 0);
        row("t2", 4, 0, 0, 1, 1, 1, 0);
        row("t2", 2, 0, 0, 0, 1, 1, 0);
        row("t2", 4, 0, 0, 1, 1, 0, 0);
        row("t2", 2, 0, 0, 0, 1, 0, 0);
        row("t2", 1, 0, 0, 0, 0, 0, 0);

        // saturation and overflow
        row("t3", 1, 1, 0, 1, 1, 0, 0);
        row("t3", 1, 1, 0, 1, 1, 1, 0);
        row("t3", 1, 1, 0, 1, 1, 2, 0);
        row("t3", 1, 1, 0, 1, 1, 3, 0);
        row("t3", 1, 1, 0, 0, 1, 3, 1);
        row("t3", 1, 1, 0, 0, 1, 3, 1);
        row("t3", 4, 0, 0, 1, 1, 2, 1);
        row("t3", 2, 0, 0, 0, 1, 2, 1);
        row("t3", 4, 0, 0, 1, 1, 1, 1);
        row("t3", 2, 0, 0, 0, 1, 1, 1);
        row("t3", 4, 0, 0, 1, 1, 0, 1);
        row("t3", 2, 0, 0, 0, 1, 0, 1);
        row("t3", 1, 0, 0, 0, 0, 0, 1);
        row("t3_clr", 1, 0, 1, 0, 0, 0, 0);

        // event on last gap cycle
        row("t4", 1, 1, 0, 1, 1, 0, 0);
        row("t4", 3, 0, 0, 1, 1, 0, 0);
        row("t4", 2, 0, 0, 0, 1, 0, 0);
        row("t4", 1, 1, 0, 1, 1, 0, 0);
        row("t4", 3, 0, 0, 1, 1, 0, 0);
        row("t4", 2, 0, 0, 0, 1, 0, 0);
        row("t4", 1, 0, 0, 0, 0, 0, 0);

        // clear with event during gap
        row("t6", 1, 1, 0, 1, 1, 0, 0);
        row("t6", 1, 1, 0, 1, 1, 1, 0);
        row("t6", 1, 1, 0, 1, 1, 2, 0);
        row("t6", 1, 1, 0, 1, 1, 3, 0);
        row("t6", 1, 1, 0, 0, 1, 3, 1);
        row("t6", 1, 1, 0, 0, 1, 3, 1);
        row("t6", 4, 0, 0, 1, 1, 2, 1);
        row("t6", 1, 0, 0, 0, 1, 2, 1);
        row("t6", 1, 1, 1, 0, 0, 0, 0);
        row("t6", 3, 0, 0, 0, 0, 0, 0);

        // async reset mid-flash
        row("t5_pre", 1, 1, 0, 1, 1, 0, 0);
        row("t5_pre", 1, 1, 0, 1, 1, 1, 0);
        @(negedge clk);
        bus.event_in = 1'b0;
        #2;
        n_reset = 1'b1;
        #1;
        check("t5_async_rst", '0);
        @(negedge clk);
        n_reset = 1'b0;
        row("t5_post", 1, 1, 0, 1, 1, 0, 0);
        row("t5_post", 3, 0, 0, 1, 1, 0, 0);
        row("t5_post", 2, 0, 0, 0, 1, 0, 0);
        row("t5_post", 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d queued, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
